cdu_drive_counter: RTL and testbench

Command-side drive-pulse generator that sits directly upstream of the CDU DAC error counter. It accepts a signed 15-bit ones-complement angle command and holds it in a drive register. While drive is enabled, it emits one fine-rate pulse per slot on AFpPCH or AFmPCH and steps the register toward zero by one per pulse. It reports busy, remaining count and completion, so the sequencer can reload or zero the channel.

---
 rtl/cdu_drive_pkg.sv | 27 ++
 rtl/cdu_drive_counter_if.sv | 24 ++
 rtl/cdu_pulse_prescaler.sv | 70 +++++++
 rtl/cdu_drive_counter.sv | 129 ++++++++++++
 tb/tb_cdu_drive_counter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdu_drive_pkg.sv
// Shared types and ones-complement helpers for the CDU drive-pulse counter.
package cdu_drive_pkg;

   localparam int unsigned CMD_W = 15;

   typedef logic [CMD_W-1:0] oc_word_t;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      PULSE
   } drive_state_t;

   function automatic logic is_zero(input oc_word_t v);
      return (v == '0) || (v == '1);
   endfunction

   function automatic oc_word_t normalize_minus_zero(input oc_word_t v);
      return (v == '1) ? '0 : v;
   endfunction

   // Negative words approach all-ones (-0), so the magnitude shrinks by incrementing.
   function automatic oc_word_t step_toward_zero(input oc_word_t v);
      return normalize_minus_zero(v[CMD_W-1] ? v + oc_word_t'(1) : v - oc_word_t'(1));
   endfunction

endpackage

// File: rtl/cdu_drive_counter_if.sv
// Command/drive bus between the sequencer (master) and the drive counter (slave).
interface cdu_drive_counter_if;
   import cdu_drive_pkg::*;

   logic     load;
   oc_word_t cmd_value;
   logic     drive_en;
   logic     zero;
   logic     AFpPCH;
   logic     AFmPCH;
   logic     busy;
   oc_word_t count;
   logic     done;

   modport master (
      output load, cmd_value, drive_en, zero,
      input  AFpPCH, AFmPCH, busy, count, done
   );

   modport slave (
      input  load, cmd_value, drive_en, zero,
      output AFpPCH, AFmPCH, busy, count, done
   );
endinterface

// File: rtl/cdu_pulse_prescaler.sv
// Slot divider plus optional burst window limiter (enabled by CDU_DRIVE_BURST_EN).
module cdu_pulse_prescaler #(
   parameter int unsigned PULSE_DIV   = 16,
   parameter int unsigned PULSE_WIDTH = 4,
   parameter int unsigned BURST_LEN   = 192,
   parameter int unsigned BURST_SLOTS = 256
) (
   input  logic clk,
   input  logic rst,
`ifdef CDU_DRIVE_BURST_EN
   input  logic i_pulse_start,
`endif
   output logic o_slot_tick,
   output logic o_burst_ok
);

   localparam int unsigned PRESC_W = $clog2(PULSE_DIV);
   // An illegal parameter set never permits a pulse rather than emitting malformed ones.
   localparam bit CFG_OK = (PULSE_DIV >= 4) && (PULSE_WIDTH >= 1) &&
                           (PULSE_WIDTH < PULSE_DIV) && (BURST_SLOTS >= BURST_LEN);

   logic [PRESC_W-1:0] r_presc;
   logic               w_slot_end;

   assign w_slot_end  = (r_presc == PRESC_W'(PULSE_DIV - 1));
   assign o_slot_tick = (r_presc == '0);

   always_ff @(posedge clk) begin
      if (rst)
         r_presc <= '0;
      else if (w_slot_end)
         r_presc <= '0;
      else
         r_presc <= r_presc + PRESC_W'(1);
   end

`ifdef CDU_DRIVE_BURST_EN
   localparam int unsigned SLOT_W = (BURST_SLOTS > 1) ? $clog2(BURST_SLOTS) : 1;
   localparam int unsigned PCNT_W = $clog2(BURST_LEN + 1);

   logic [SLOT_W-1:0] r_slot;
   logic [PCNT_W-1:0] r_pcnt;
   logic              w_wrap;

   // Slot index advances at the end of each slot so it is stable during the tick cycle.
   assign w_wrap = w_slot_end && (r_slot == SLOT_W'(BURST_SLOTS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot <= '0;
         r_pcnt <= '0;
      end else begin
         if (w_wrap)
            r_slot <= '0;
         else if (w_slot_end)
            r_slot <= r_slot + SLOT_W'(1);

         if (w_wrap)
            r_pcnt <= '0;
         else if (i_pulse_start)
            r_pcnt <= r_pcnt + PCNT_W'(1);
      end
   end

   assign o_burst_ok = CFG_OK && (r_pcnt < PCNT_W'(BURST_LEN));
`else
   assign o_burst_ok = CFG_OK;
`endif

endmodule

// File: rtl/cdu_drive_counter.sv
// Drive register that drains toward zero one AFpPCH/AFmPCH pulse per slot.
// Burst windowing is compiled in with CDU_DRIVE_BURST_EN.
module cdu_drive_counter
   import cdu_drive_pkg::*;
#(
   parameter int unsigned PULSE_DIV   = 16,
   parameter int unsigned PULSE_WIDTH = 4,
   parameter int unsigned BURST_LEN   = 192,
   parameter int unsigned BURST_SLOTS = 256
) (
   input  logic               clk,
   input  logic               rst,
   cdu_drive_counter_if.slave bus
);

   localparam int unsigned WCNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

   drive_state_t      r_state;
   drive_state_t      w_state_nxt;
   oc_word_t          r_drive;
   oc_word_t          w_stepped;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_afp;
   logic              r_afm;
   logic              r_done;
   logic              w_tick;
   logic              w_burst_ok;
   logic              w_nz;
   logic              w_last;
   logic              w_start;
   logic              w_afp_nxt;
   logic              w_afm_nxt;

   cdu_pulse_prescaler #(
      .PULSE_DIV   (PULSE_DIV),
      .PULSE_WIDTH (PULSE_WIDTH),
      .BURST_LEN   (BURST_LEN),
      .BURST_SLOTS (BURST_SLOTS)
   ) u_prescaler (
      .clk           (clk),
      .rst           (rst),
`ifdef CDU_DRIVE_BURST_EN
      .i_pulse_start (w_start),
`endif
      .o_slot_tick   (w_tick),
      .o_burst_ok    (w_burst_ok)
   );

   assign w_nz      = !is_zero(r_drive);
   assign w_last    = (r_wcnt == WCNT_W'(PULSE_WIDTH - 1));
   assign w_stepped = step_toward_zero(r_drive);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_nz && bus.drive_en)
               w_state_nxt = ARMED;
         end
         ARMED: begin
            if (!w_nz || !bus.drive_en)
               w_state_nxt = IDLE;
            else if (w_tick && w_burst_ok)
               w_state_nxt = PULSE;
         end
         PULSE: begin
            if (w_last)
               w_state_nxt = (w_nz && bus.drive_en) ? ARMED : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The pulse polarity is fixed at launch and simply held, so a load mid-pulse cannot flip it.
   always_comb begin
      w_start   = (r_state == ARMED) && (w_state_nxt == PULSE);
      w_afp_nxt = 1'b0;
      w_afm_nxt = 1'b0;
      if (w_start) begin
         w_afp_nxt = !r_drive[CMD_W-1];
         w_afm_nxt =  r_drive[CMD_W-1];
      end else if ((r_state == PULSE) && !w_last) begin
         w_afp_nxt = r_afp;
         w_afm_nxt = r_afm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drive <= '0;
         r_wcnt  <= '0;
         r_afp   <= 1'b0;
         r_afm   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_afp  <= w_afp_nxt;
         r_afm  <= w_afm_nxt;
         r_done <= 1'b0;

         if (w_start)
            r_wcnt <= '0;
         else if (r_state == PULSE)
            r_wcnt <= r_wcnt + WCNT_W'(1);

         if (bus.zero)
            r_drive <= '0;
         else if (bus.load)
            r_drive <= normalize_minus_zero(bus.cmd_value);
         else if (w_start) begin
            r_drive <= w_stepped;
            r_done  <= is_zero(w_stepped);
         end
      end
   end

   assign bus.AFpPCH = r_afp;
   assign bus.AFmPCH = r_afm;
   assign bus.busy   = w_nz || r_afp || r_afm;
   assign bus.count  = r_drive;
   assign bus.done   = r_done;

endmodule

// File: tb/tb_cdu_drive_counter.sv
// Randomized bench for cdu_drive_counter against a signed-integer reference model.
// Burst scenario is included when CDU_DRIVE_BURST_EN is defined.
module tb_cdu_drive_counter;

   localparam int unsigned DIV    = 16;
   localparam int unsigned WID    = 4;
   localparam int unsigned BLEN   = 192;
   localparam int unsigned BSLOTS = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cdu_drive_counter_if bus ();

   cdu_drive_counter #(
      .PULSE_DIV   (DIV),
      .PULSE_WIDTH (WID),
      .BURST_LEN   (BLEN),
      .BURST_SLOTS (BSLOTS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic int oc2int(input logic [14:0] w);
      logic [14:0] mag;
      mag = w[14] ? ~w : w;
      return w[14] ? -int'(mag) : int'(mag);
   endfunction

   function automatic logic [14:0] int2oc(input int v);
      logic [14:0] mag;
      mag = 15'(v < 0 ? -v : v);
      return (v < 0) ? ~mag : mag;
   endfunction

   // Reference model: drive value as a signed integer, pulses as a countdown of high cycles.
   int m_val       = 0;
   int m_pulse     = 0;
   int m_pol       = 0;
   bit m_prev_ok   = 0;
   bit m_done      = 0;
   bit m_live      = 0;
   int m_phase     = 0;
`ifdef CDU_DRIVE_BURST_EN
   int m_ticks     = 0;
   int m_win_id    = 0;
   int m_win_cnt   = 0;
`endif

   always @(posedge clk) begin
      bit tick;
      bit ok;
      bit start;
      m_live = 1;
      if (rst) begin
         m_val = 0; m_pulse = 0; m_pol = 0; m_prev_ok = 0; m_done = 0; m_phase = 0;
`ifdef CDU_DRIVE_BURST_EN
         m_ticks = 0; m_win_id = 0; m_win_cnt = 0;
`endif
      end else begin
         tick = (m_phase == 0);
         ok   = 1;
`ifdef CDU_DRIVE_BURST_EN
         if (tick) begin
            if (m_ticks / int'(BSLOTS) != m_win_id) begin
               m_win_id  = m_ticks / int'(BSLOTS);
               m_win_cnt = 0;
            end
            ok = (m_win_cnt < int'(BLEN));
         end
`endif
         start     = tick && (m_pulse == 0) && m_prev_ok && (m_val != 0) && bus.drive_en && ok;
         m_prev_ok = (m_val != 0) && bus.drive_en;
         if (m_pulse > 0) m_pulse--;
         m_done = 0;
         if (start) begin
            m_pol   = (m_val > 0) ? 1 : -1;
            m_pulse = WID;
`ifdef CDU_DRIVE_BURST_EN
            m_win_cnt++;
`endif
         end
         if (bus.zero)
            m_val = 0;
         else if (bus.load)
            m_val = oc2int(bus.cmd_value);
         else if (start) begin
            m_val  = m_val - m_pol;
            m_done = (m_val == 0);
         end
`ifdef CDU_DRIVE_BURST_EN
         if (tick) m_ticks++;
`endif
         m_phase = (m_phase + 1) % DIV;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("AFpPCH", bus.AFpPCH, (m_pulse > 0) && (m_pol > 0));
         chk("AFmPCH", bus.AFmPCH, (m_pulse > 0) && (m_pol < 0));
         chk("count",  bus.count,  int2oc(m_val));
         chk("busy",   bus.busy,   (m_val != 0) || (m_pulse > 0));
         chk("done",   bus.done,   m_done);
      end
   end

   // Observed event counters, sampled just after the active edge.
   int n_pp = 0;
   int n_mp = 0;
   int n_done = 0;
   logic prev_p = 1'b0;
   logic prev_m = 1'b0;

   always @(posedge clk) begin
      #1;
      if (bus.AFpPCH && !prev_p) n_pp++;
      if (bus.AFmPCH && !prev_m) n_mp++;
      if (bus.done) n_done++;
      prev_p = bus.AFpPCH;
      prev_m = bus.AFmPCH;
   end

   task automatic clear_counts();
      n_pp = 0; n_mp = 0; n_done = 0;
   endtask

   task automatic do_load(input logic [14:0] v);
      bus.load = 1'b1; bus.cmd_value = v;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic do_zero();
      bus.zero = 1'b1;
      @(negedge clk);
      bus.zero = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (bus.busy && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", bus.busy, 1'b0);
   endtask

   task automatic wait_pulse(input int max_cyc);
      int n;
      n = 0;
      while (!(bus.AFpPCH || bus.AFmPCH) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("pulse_timeout", bus.AFpPCH | bus.AFmPCH, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned act;
      int unsigned mag;
      logic [14:0] v;

      bus.load = 1'b0; bus.cmd_value = '0; bus.drive_en = 1'b0; bus.zero = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_count", bus.count, 15'h0000);
      chk("rst_busy",  bus.busy,  1'b0);
      chk("rst_pulse", bus.AFpPCH | bus.AFmPCH, 1'b0);
      rst = 1'b0;
      bus.drive_en = 1'b1;

      // +5 drains with five positive pulses and one done
      clear_counts();
      do_load(15'd5);
      wait_idle(400);
      chk("p5_pulses",  n_pp,      5);
      chk("p5_neg",     n_mp,      0);
      chk("p5_done",    n_done,    1);
      chk("p5_count",   bus.count, 15'h0000);

      // -5 drains with five negative pulses
      clear_counts();
      do_load(15'h7FFA);
      wait_idle(400);
      chk("m5_pulses",  n_mp,      5);
      chk("m5_pos",     n_pp,      0);
      chk("m5_done",    n_done,    1);

      // -0 stores +0 and stays quiet
      clear_counts();
      do_load(15'h7FFF);
      chk("mz_count", bus.count, 15'h0000);
      chk("mz_busy",  bus.busy,  1'b0);
      repeat (3 * DIV) @(negedge clk);
      chk("mz_pulses", n_pp + n_mp, 0);
      chk("mz_done",   n_done,      0);

      // drive_en drop mid-pulse holds the count, re-enable resumes
      do_load(15'd100);
      wait_pulse(4 * DIV);
      repeat (3 * DIV) @(negedge clk);
      wait_pulse(2 * DIV);
      bus.drive_en = 1'b0;
      repeat (WID + 2) @(negedge clk);
      clear_counts();
      repeat (8 * DIV) @(negedge clk);
      chk("hold_no_pulse", n_pp, 0);
      bus.drive_en = 1'b1;
      repeat (6 * DIV) @(negedge clk);
      chk("resume", n_pp >= 4, 1'b1);
      do_zero();
      wait_idle(4 * DIV);

      // load and zero together during a pulse
      do_load(15'd20);
      wait_pulse(4 * DIV);
      clear_counts();
      bus.load = 1'b1; bus.cmd_value = 15'd7; bus.zero = 1'b1;
      @(negedge clk);
      bus.load = 1'b0; bus.zero = 1'b0;
      repeat (WID + 20) @(negedge clk);
      chk("lz_count", bus.count, 15'h0000);
      chk("lz_done",  n_done,    0);
      chk("lz_busy",  bus.busy,  1'b0);

      // randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 250; i++) begin
         act = $urandom_range(0, 11);
         mag = $urandom_range(0, 12);
         v = 15'(mag);
         if ($urandom_range(0, 1) == 1) v = ~v;
         if (act < 6)
            do_load(v);
         else if (act == 6)
            do_zero();
         else if (act == 7) begin
            bus.load = 1'b1; bus.cmd_value = v; bus.zero = 1'b1;
            @(negedge clk);
            bus.load = 1'b0; bus.zero = 1'b0;
         end else if (act == 8)
            bus.drive_en = ($urandom_range(0, 3) != 0);
         else if (act == 9) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            rst = 1'b0;
         end else if (act == 10)
            do_load(15'h7FFF);
         else
            bus.drive_en = 1'b1;
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      bus.drive_en = 1'b1;
      do_zero();
      wait_idle(4 * DIV);

`ifdef CDU_DRIVE_BURST_EN
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
      do_load(15'd300);
      wait_idle(30000);
      chk("burst_pulses", n_pp,   300);
      chk("burst_done",   n_done, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
